// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the 32-bit bus datapath.
// State codes: RST=0 T0=1 T1=2 T2=3 DEC=4 E1..E4=5..8 HALT=9, E5 = E4 with bit 4 set.
module control_sequencer #(
    parameter int BITS = 32,
    parameter int OPW  = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [BITS-1:0] IRVal,
    input  logic            CON,
    input  logic            stop,
    output logic            PCout,
    output logic            MDRout,
    output logic            RZout,
    output logic            HILOout,
    output logic            Cout,
    output logic            BAout,
    output logic            Rout,
    output logic            PCin,
    output logic            IRin,
    output logic            RYin,
    output logic            RZin,
    output logic            MARin,
    output logic            MDRin,
    output logic            HILOin,
    output logic            CONin,
    output logic            Rin,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            ADD,
    output logic            SUB,
    output logic            MUL,
    output logic            DIV,
    output logic            SHR,
    output logic            SHL,
    output logic            ROR,
    output logic            ROL,
    output logic            AND,
    output logic            OR,
    output logic            NEGATE,
    output logic            NOT,
    output logic            IncPC,
    output logic            Read,
    output logic            Write,
    output logic            run,
    output logic [4:0]      state
);

    localparam logic [4:0] S_RST  = 5'd0;
    localparam logic [4:0] S_T0   = 5'd1;
    localparam logic [4:0] S_T1   = 5'd2;
    localparam logic [4:0] S_T2   = 5'd3;
    localparam logic [4:0] S_DEC  = 5'd4;
    localparam logic [4:0] S_E1   = 5'd5;
    localparam logic [4:0] S_E2   = 5'd6;
    localparam logic [4:0] S_E3   = 5'd7;
    localparam logic [4:0] S_E4   = 5'd8;
    localparam logic [4:0] S_HALT = 5'd9;
    localparam logic [4:0] S_E5   = 5'd24;

    localparam logic [OPW-1:0] OP_LD   = OPW'(0);
    localparam logic [OPW-1:0] OP_LDI  = OPW'(1);
    localparam logic [OPW-1:0] OP_ST   = OPW'(2);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(4);
    localparam logic [OPW-1:0] OP_SHR  = OPW'(5);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(6);
    localparam logic [OPW-1:0] OP_ROR  = OPW'(7);
    localparam logic [OPW-1:0] OP_ROL  = OPW'(8);
    localparam logic [OPW-1:0] OP_AND  = OPW'(9);
    localparam logic [OPW-1:0] OP_OR   = OPW'(10);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(11);
    localparam logic [OPW-1:0] OP_ANDI = OPW'(12);
    localparam logic [OPW-1:0] OP_ORI  = OPW'(13);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(14);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(15);
    localparam logic [OPW-1:0] OP_NEG  = OPW'(16);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(17);
    localparam logic [OPW-1:0] OP_BR   = OPW'(18);
    localparam logic [OPW-1:0] OP_HALT = OPW'(26);

    logic [4:0]     nxt;
    logic [OPW-1:0] opc, op_q;
    logic           unused_ir;
    logic           is_rtype, is_imm, is_ldi, is_ld, is_st, is_md, is_neg, is_br, last;

    assign opc       = IRVal[BITS-1:BITS-OPW];
    assign unused_ir = ^IRVal[BITS-OPW-1:0];

    assign is_rtype = (op_q >= OP_ADD) && (op_q <= OP_OR);
    assign is_imm   = (op_q >= OP_ADDI) && (op_q <= OP_ORI);
    assign is_ldi   = (op_q == OP_LDI);
    assign is_ld    = (op_q == OP_LD);
    assign is_st    = (op_q == OP_ST);
    assign is_md    = (op_q == OP_MUL) || (op_q == OP_DIV);
    assign is_neg   = (op_q == OP_NEG) || (op_q == OP_NOT);
    assign is_br    = (op_q == OP_BR);

    // Final execute step per instruction class; stop is only honoured here.
    assign last = ((state == S_E2) && is_neg) ||
                  ((state == S_E3) && (is_rtype || is_imm || is_ldi || is_md)) ||
                  ((state == S_E4) && is_br) ||
                  ((state == S_E5) && (is_ld || is_st));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_RST;
            op_q  <= '0;
        end else begin
            state <= nxt;
            if (state == S_DEC) op_q <= opc;
        end
    end

    always_comb begin
        nxt = S_T0;
        case (state)
            S_RST:  nxt = S_T0;
            S_T0:   nxt = S_T1;
            S_T1:   nxt = S_T2;
            S_T2:   nxt = S_DEC;
            S_DEC: begin
                if (opc == OP_HALT)     nxt = S_HALT;
                else if (opc <= OP_BR)  nxt = S_E1;
                else                    nxt = stop ? S_HALT : S_T0;
            end
            S_E1, S_E2, S_E3, S_E4, S_E5: begin
                if (last)               nxt = stop ? S_HALT : S_T0;
                else if (state == S_E1) nxt = S_E2;
                else if (state == S_E2) nxt = S_E3;
                else if (state == S_E3) nxt = S_E4;
                else if (state == S_E4) nxt = S_E5;
                else                    nxt = S_T0;
            end
            S_HALT: nxt = S_HALT;
            default: nxt = S_RST;
        endcase
    end

    always_comb begin
        {PCout, MDRout, RZout, HILOout, Cout, BAout, Rout}               = '0;
        {PCin, IRin, RYin, RZin, MARin, MDRin, HILOin, CONin, Rin}       = '0;
        {Gra, Grb, Grc}                                                  = '0;
        {ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT}   = '0;
        {IncPC, Read, Write}                                             = '0;
        run = (state != S_RST) && (state != S_HALT);
        case (state)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; RZin = 1'b1; end
            S_T1: begin RZout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_E1: begin
                if (is_md) begin
                    Gra = 1'b1; Rout = 1'b1; RYin = 1'b1;
                end else if (is_neg) begin
                    Grb = 1'b1; Rout = 1'b1; RZin = 1'b1;
                    NEGATE = (op_q == OP_NEG);
                    NOT    = (op_q == OP_NOT);
                end else if (is_br) begin
                    Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
                end else if (is_ldi || is_ld || is_st) begin
                    Grb = 1'b1; BAout = 1'b1; RYin = 1'b1;
                end else if (is_rtype || is_imm) begin
                    Grb = 1'b1; Rout = 1'b1; RYin = 1'b1;
                end
            end
            S_E2: begin
                if (is_rtype || is_imm) begin
                    Grc  = is_rtype;
                    Rout = is_rtype;
                    Cout = is_imm;
                    RZin = 1'b1;
                    ADD  = (op_q == OP_ADD) || (op_q == OP_ADDI);
                    SUB  = (op_q == OP_SUB);
                    SHR  = (op_q == OP_SHR);
                    SHL  = (op_q == OP_SHL);
                    ROR  = (op_q == OP_ROR);
                    ROL  = (op_q == OP_ROL);
                    AND  = (op_q == OP_AND) || (op_q == OP_ANDI);
                    OR   = (op_q == OP_OR)  || (op_q == OP_ORI);
                end else if (is_ldi || is_ld || is_st) begin
                    Cout = 1'b1; ADD = 1'b1; RZin = 1'b1;
                end else if (is_md) begin
                    Grb = 1'b1; Rout = 1'b1; RZin = 1'b1;
                    MUL = (op_q == OP_MUL);
                    DIV = (op_q == OP_DIV);
                end else if (is_neg) begin
                    RZout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_br) begin
                    PCout = 1'b1; RYin = 1'b1;
                end
            end
            S_E3: begin
                if (is_rtype || is_imm || is_ldi) begin
                    RZout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_ld || is_st) begin
                    RZout = 1'b1; MARin = 1'b1;
                end else if (is_md) begin
                    RZout = 1'b1; HILOin = 1'b1;
                end else if (is_br) begin
                    Cout = 1'b1; ADD = 1'b1; RZin = 1'b1;
                end
            end
            S_E4: begin
                if (is_ld) begin
                    Read = 1'b1; MDRin = 1'b1;
                end else if (is_st) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end else if (is_br) begin
                    RZout = 1'b1; PCin = CON;
                end
            end
            S_E5: begin
                if (is_ld) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_st) begin
                    Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed per-cycle vector bench for control_sequencer plus reset/halt corner sequences.
module tb_control_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [31:0] IRVal = 32'h0;
    logic CON = 1'b0;
    logic stop = 1'b0;
    logic PCout, MDRout, RZout, HILOout, Cout, BAout, Rout;
    logic PCin, IRin, RYin, RZin, MARin, MDRin, HILOin, CONin, Rin;
    logic Gra, Grb, Grc;
    logic ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC;
    logic Read, Write, run;
    logic [4:0] state;

    control_sequencer #(.BITS(32), .OPW(5)) dut (
        .clk(clk), .reset(reset), .IRVal(IRVal), .CON(CON), .stop(stop),
        .PCout(PCout), .MDRout(MDRout), .RZout(RZout), .HILOout(HILOout),
        .Cout(Cout), .BAout(BAout), .Rout(Rout),
        .PCin(PCin), .IRin(IRin), .RYin(RYin), .RZin(RZin), .MARin(MARin),
        .MDRin(MDRin), .HILOin(HILOin), .CONin(CONin), .Rin(Rin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR), .SHL(SHL),
        .ROR(ROR), .ROL(ROL), .AND(AND), .OR(OR), .NEGATE(NEGATE), .NOT(NOT),
        .IncPC(IncPC), .Read(Read), .Write(Write), .run(run), .state(state)
    );

    always #5 clk = ~clk;

    logic [34:0] ctl;
    assign ctl = {run, Write, Read, IncPC, NOT, NEGATE, OR, AND, ROL, ROR, SHL, SHR,
                  DIV, MUL, SUB, ADD, Grc, Grb, Gra, Rin, CONin, HILOin, MDRin, MARin,
                  RZin, RYin, IRin, PCin, Rout, BAout, Cout, HILOout, RZout, MDRout, PCout};

    localparam logic [34:0] ONE = 35'd1;
    localparam logic [34:0] M_PCOUT = ONE << 0,  M_MDROUT = ONE << 1,  M_RZOUT = ONE << 2;
    localparam logic [34:0] M_COUT  = ONE << 4,  M_BAOUT  = ONE << 5,  M_ROUT  = ONE << 6;
    localparam logic [34:0] M_PCIN  = ONE << 7,  M_IRIN   = ONE << 8,  M_RYIN  = ONE << 9;
    localparam logic [34:0] M_RZIN  = ONE << 10, M_MARIN  = ONE << 11, M_MDRIN = ONE << 12;
    localparam logic [34:0] M_HILOIN = ONE << 13, M_CONIN = ONE << 14, M_RIN   = ONE << 15;
    localparam logic [34:0] M_GRA   = ONE << 16, M_GRB    = ONE << 17, M_GRC   = ONE << 18;
    localparam logic [34:0] M_ADD   = ONE << 19, M_SUB    = ONE << 20, M_MUL   = ONE << 21;
    localparam logic [34:0] M_OR    = ONE << 28, M_NOT    = ONE << 30, M_INCPC = ONE << 31;
    localparam logic [34:0] M_READ  = ONE << 32, M_WRITE  = ONE << 33, M_RUN   = ONE << 34;

    localparam logic [34:0] C_T0  = M_PCOUT | M_MARIN | M_INCPC | M_RZIN | M_RUN;
    localparam logic [34:0] C_T1  = M_RZOUT | M_PCIN | M_READ | M_MDRIN | M_RUN;
    localparam logic [34:0] C_T2  = M_MDROUT | M_IRIN | M_RUN;
    localparam logic [34:0] C_WB  = M_RZOUT | M_GRA | M_RIN | M_RUN;
    localparam logic [34:0] C_BA  = M_GRB | M_BAOUT | M_RYIN | M_RUN;
    localparam logic [34:0] C_CADD = M_COUT | M_ADD | M_RZIN | M_RUN;
    localparam logic [34:0] C_RB  = M_GRB | M_ROUT | M_RYIN | M_RUN;

    localparam logic [4:0] S_RST = 0, S_T0 = 1, S_T1 = 2, S_T2 = 3, S_DEC = 4;
    localparam logic [4:0] S_E1 = 5, S_E2 = 6, S_E3 = 7, S_E4 = 8, S_HALT = 9, S_E5 = 24;

    localparam logic [31:0] I_LDI = 32'h0900_0045, I_ADD = 32'h1989_0000, I_ST = 32'h1100_0010;
    localparam logic [31:0] I_BR  = 32'h9080_0000, I_LD  = 32'h0000_0000, I_MUL = 32'h7000_0000;
    localparam logic [31:0] I_NOT = 32'h8800_0000, I_ORI = 32'h6800_0000, I_NOP = 32'hC800_0000;
    localparam logic [31:0] I_ILL = 32'hF800_0000, I_SUB = 32'h2000_0000, I_HALT = 32'hD000_0000;

    typedef struct {
        logic [31:0] ir;
        logic        con;
        logic        stp;
        logic [4:0]  st;
        logic [34:0] c;
    } vec_t;

    vec_t tbl[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%09h expected 0x%09h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic v(input logic [31:0] ir, input logic con, input logic stp,
                     input logic [4:0] st, input logic [34:0] c);
        vec_t e;
        e.ir = ir; e.con = con; e.stp = stp; e.st = st; e.c = c;
        tbl.push_back(e);
    endtask

    task automatic fetch(input logic [31:0] ir, input logic con);
        v(ir, con, 1'b0, S_T0, C_T0);
        v(ir, con, 1'b0, S_T1, C_T1);
        v(ir, con, 1'b0, S_T2, C_T2);
        v(ir, con, 1'b0, S_DEC, M_RUN);
    endtask

    initial begin
        // ldi R2,0x45
        fetch(I_LDI, 0);
        v(I_LDI, 0, 0, S_E1, C_BA);
        v(I_LDI, 0, 0, S_E2, C_CADD);
        v(I_LDI, 0, 0, S_E3, C_WB);
        // add R3,R1,R2
        fetch(I_ADD, 0);
        v(I_ADD, 0, 0, S_E1, C_RB);
        v(I_ADD, 0, 0, S_E2, M_GRC | M_ROUT | M_ADD | M_RZIN | M_RUN);
        v(I_ADD, 0, 0, S_E3, C_WB);
        // st
        fetch(I_ST, 0);
        v(I_ST, 0, 0, S_E1, C_BA);
        v(I_ST, 0, 0, S_E2, C_CADD);
        v(I_ST, 0, 0, S_E3, M_RZOUT | M_MARIN | M_RUN);
        v(I_ST, 0, 0, S_E4, M_GRA | M_ROUT | M_MDRIN | M_RUN);
        v(I_ST, 0, 0, S_E5, M_WRITE | M_RUN);
        // br, CON=0 then CON=1
        fetch(I_BR, 0);
        v(I_BR, 0, 0, S_E1, M_GRA | M_ROUT | M_CONIN | M_RUN);
        v(I_BR, 0, 0, S_E2, M_PCOUT | M_RYIN | M_RUN);
        v(I_BR, 0, 0, S_E3, C_CADD);
        v(I_BR, 0, 0, S_E4, M_RZOUT | M_RUN);
        fetch(I_BR, 1);
        v(I_BR, 1, 0, S_E1, M_GRA | M_ROUT | M_CONIN | M_RUN);
        v(I_BR, 1, 0, S_E2, M_PCOUT | M_RYIN | M_RUN);
        v(I_BR, 1, 0, S_E3, C_CADD);
        v(I_BR, 1, 0, S_E4, M_RZOUT | M_PCIN | M_RUN);
        // ld
        fetch(I_LD, 0);
        v(I_LD, 0, 0, S_E1, C_BA);
        v(I_LD, 0, 0, S_E2, C_CADD);
        v(I_LD, 0, 0, S_E3, M_RZOUT | M_MARIN | M_RUN);
        v(I_LD, 0, 0, S_E4, M_READ | M_MDRIN | M_RUN);
        v(I_LD, 0, 0, S_E5, M_MDROUT | M_GRA | M_RIN | M_RUN);
        // mul
        fetch(I_MUL, 0);
        v(I_MUL, 0, 0, S_E1, M_GRA | M_ROUT | M_RYIN | M_RUN);
        v(I_MUL, 0, 0, S_E2, M_GRB | M_ROUT | M_MUL | M_RZIN | M_RUN);
        v(I_MUL, 0, 0, S_E3, M_RZOUT | M_HILOIN | M_RUN);
        // not
        fetch(I_NOT, 0);
        v(I_NOT, 0, 0, S_E1, M_GRB | M_ROUT | M_NOT | M_RZIN | M_RUN);
        v(I_NOT, 0, 0, S_E2, C_WB);
        // ori
        fetch(I_ORI, 0);
        v(I_ORI, 0, 0, S_E1, C_RB);
        v(I_ORI, 0, 0, S_E2, M_COUT | M_OR | M_RZIN | M_RUN);
        v(I_ORI, 0, 0, S_E3, C_WB);
        // nop and illegal return straight to fetch
        fetch(I_NOP, 0);
        fetch(I_ILL, 0);
        // sub with stop raised during E2: completes, then halts
        fetch(I_SUB, 0);
        v(I_SUB, 0, 0, S_E1, C_RB);
        v(I_SUB, 0, 1, S_E2, M_GRC | M_ROUT | M_SUB | M_RZIN | M_RUN);
        v(I_SUB, 0, 1, S_E3, C_WB);
        v(I_SUB, 0, 1, S_HALT, '0);
        v(I_SUB, 0, 0, S_HALT, '0);
        v(I_LDI, 0, 0, S_HALT, '0);

        // reset held 3 cycles
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("reset_ctl", ctl, '0);
            chk("reset_state", 35'(state), 35'(S_RST));
        end
        @(negedge clk) reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            IRVal = tbl[i].ir; CON = tbl[i].con; stop = tbl[i].stp;
            #1;
            chk($sformatf("vec%0d_state", i), 35'(state), 35'(tbl[i].st));
            chk($sformatf("vec%0d_ctl", i), ctl, tbl[i].c);
        end

        // halt opcode after reset
        stop = 1'b0; IRVal = I_HALT;
        @(negedge clk) reset = 1'b0;
        #1 chk("halt_rst_ctl", ctl, '0);
        @(negedge clk) reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("halt_state", 35'(state), 35'(S_HALT));
        chk("halt_ctl", ctl, '0);
        repeat (3) @(posedge clk);
        #1 chk("halt_stays", 35'(state), 35'(S_HALT));

        // reset asserted during ld E4 clears outputs without waiting for a clock
        IRVal = I_LD;
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("ld_e4_state", 35'(state), 35'(S_E4));
        chk("ld_e4_ctl", ctl, M_READ | M_MDRIN | M_RUN);
        #1 reset = 1'b0;
        #1;
        chk("async_rst_ctl", ctl, '0);
        chk("async_rst_state", 35'(state), 35'(S_RST));
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_t0", ctl, C_T0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete, expected finish before 20000");
        $fatal(1);
    end

endmodule
